// File: rtl/rand_arbiter_pkg.sv
// Shared definitions for the random-word arbiter: FSM encoding, LFSR taps, defaults.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  // Fibonacci taps for the 6-bit maximal-length (period 63) sequence.
  localparam int TAP_HI = 5;
  localparam int TAP_LO = 4;

  localparam int         DATA_W_DEF = 6;
  localparam logic [5:0] SEED_DEF   = 6'h01;

endpackage

// File: rtl/rand_arbiter_if.sv
// Request/grant bundle between requesters and the random-word arbiter.
// Latency: n/a (wiring only).
// Backpressure: 4-phase level request; ack is a single-cycle one-hot pulse.
// Signals: req (per-requester level request), ack (one-hot grant pulse),
//          rand_data (random word, valid while ack is high), busy (arbiter not idle).
interface rand_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 6
);
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  ack;
  logic [DATA_W-1:0] rand_data;
  logic              busy;

  modport master (output req, input ack, input rand_data, input busy);
  modport slave  (input req, output ack, output rand_data, output busy);
endinterface

// File: rtl/rand_arbiter_rr_pick.sv
// Round-robin selector: first asserted request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; found is low when no request is pending.
// Ports: req (request vector), ptr (search start), g (chosen index), found (any request seen).
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] g,
  output logic             found
);

  always_comb begin
    found = 1'b0;
    g     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((int'(ptr) + i) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
  end

endmodule

// File: rtl/rand_arbiter.sv
// Hands out words from a free-running 6-bit LFSR to N_REQ requesters, round-robin.
// Latency: ack/rand_data one cycle after req is seen in IDLE; ack lasts one cycle.
// Backpressure: after a grant, waits for the granted req to drop before re-arbitrating.
// Ports: clk, rst (async active-low), bus (slave side of rand_arbiter_if).
// Optional build macro RAND_RESEED_EN adds seed_ld/seed to load the LFSR.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter int                N_REQ  = 4,
  parameter int                DATA_W = DATA_W_DEF,
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(SEED_DEF)
) (
  input  logic          clk,
  input  logic          rst,
`ifdef RAND_RESEED_EN
  input  logic              seed_ld,
  input  logic [DATA_W-1:0] seed,
`endif
  rand_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  g_q, g_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic [DATA_W-1:0] rand_q, rand_d;
  logic [DATA_W-1:0] lfsr_q, lfsr_d;
  logic [PTR_W-1:0]  pick_g;
  logic              pick_found;

  rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .g     (pick_g),
    .found (pick_found)
  );

  // LFSR advances every edge regardless of FSM state; all-zero is forced back
  // to 1 so a corrupted or loaded zero cannot lock the sequence.
  always_comb begin
    if (lfsr_q == '0) lfsr_d = DATA_W'(1);
    else              lfsr_d = {lfsr_q[DATA_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO]};
`ifdef RAND_RESEED_EN
    if (seed_ld) lfsr_d = (seed == '0) ? DATA_W'(1) : seed;
`endif
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    ack_d   = '0;
    rand_d  = rand_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d       = ST_GRANT;
          g_d           = pick_g;
          ptr_d         = (int'(pick_g) == N_REQ - 1) ? '0 : pick_g + 1'b1;
          ack_d[pick_g] = 1'b1;
          rand_d        = lfsr_q;  // pre-advance value
        end
      end
      ST_GRANT:    state_d = ST_WAIT_REL;
      // Only the granted requester matters here; others wait for IDLE.
      ST_WAIT_REL: if (!bus.req[g_q]) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      ack_q   <= '0;
      rand_q  <= '0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      ack_q   <= ack_d;
      rand_q  <= rand_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.rand_data = rand_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rand_arbiter.sv
module tb_rand_arbiter;

  logic clk;
  logic rst;
`ifdef RAND_RESEED_EN
  logic       seed_ld;
  logic [5:0] seed;
`endif

  int checks;
  int errors;

  rand_arbiter_if #(.N_REQ(4), .DATA_W(6)) bus ();

  rand_arbiter dut (
    .clk     (clk),
    .rst     (rst),
`ifdef RAND_RESEED_EN
    .seed_ld (seed_ld),
    .seed    (seed),
`endif
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] ack;
    logic       busy;
    logic       chk_rand;
    logic [5:0] rnd;
  } vec_t;

  vec_t tbl [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [5:0] fr [6];
    logic [5:0] rv [4];
    logic [3:0] seen;
    bit         got;

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.req = 4'b0000;
`ifdef RAND_RESEED_EN
    seed_ld = 1'b0;
    seed    = 6'h00;
`endif

    // Free-running sequence straight out of reset with no requests.
    fr[0] = 6'h01; fr[1] = 6'h02; fr[2] = 6'h04;
    fr[3] = 6'h08; fr[4] = 6'h10; fr[5] = 6'h21;
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("freerun_%0d", i), 32'(dut.lfsr_q), 32'(fr[i]));
      tick();
    end

    // Per-cycle vectors: {rst_n, req, exp ack, exp busy, check rand?, exp rand}
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 6'h00};
    tbl[1]  = '{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1, 6'h01};
    tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 6'h01};
    tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 6'h00};
    tbl[4]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 6'h00};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 6'h00};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 6'h00};
    tbl[7]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 6'h03};
    tbl[8]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 6'h00};
    tbl[9]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 6'h00};
    tbl[10] = '{1'b1, 4'b0011, 4'b0001, 1'b1, 1'b1, 6'h18};
    tbl[11] = '{1'b1, 4'b0010, 4'b0000, 1'b1, 1'b0, 6'h00};
    tbl[12] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 1'b0, 6'h00};
    tbl[13] = '{1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1, 6'h05};
    tbl[14] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 6'h05};
    tbl[15] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 6'h00};

    for (int v = 0; v < 16; v++) begin
      rst     = tbl[v].rst_n;
      bus.req = tbl[v].req;
      tick();
      chk($sformatf("vec%0d_ack", v), 32'(bus.ack), 32'(tbl[v].ack));
      chk($sformatf("vec%0d_busy", v), 32'(bus.busy), 32'(tbl[v].busy));
      if (tbl[v].chk_rand)
        chk($sformatf("vec%0d_rand", v), 32'(bus.rand_data), 32'(tbl[v].rnd));
    end

    // Round-robin with all four requesting; each drops the cycle after its ack.
    rst     = 1'b0;
    bus.req = 4'b0000;
    tick();
    rst     = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      got  = 1'b0;
      seen = 4'b0000;
      for (int c = 0; c < 8 && !got; c++) begin
        tick();
        if (bus.ack != 4'b0000) begin
          got  = 1'b1;
          seen = bus.ack;
          rv[i] = bus.rand_data;
        end
      end
      chk($sformatf("rr_got_%0d", i), 32'(got), 32'd1);
      chk($sformatf("rr_ack_%0d", i), 32'(seen), 32'(4'b0001 << i));
      tick();
      bus.req = bus.req & ~seen;
    end
    for (int i = 0; i < 4; i++)
      for (int j = i + 1; j < 4; j++)
        chk($sformatf("rr_rand_distinct_%0d_%0d", i, j), 32'(rv[i] != rv[j]), 32'd1);
    tick();
    tick();

    // Reset pulled mid-grant: ack must vanish immediately.
    bus.req = 4'b0001;
    tick();
    chk("midrst_ack_before", 32'(bus.ack), 32'(4'b0001));
    rst = 1'b0;
    #1;
    chk("midrst_ack_dropped", 32'(bus.ack), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.req = 4'b0000;
    tick();
    rst = 1'b1;
    chk("midrst_ptr", 32'(dut.ptr_q), 32'd0);
    chk("midrst_lfsr", 32'(dut.lfsr_q), 32'h01);
    // First edge after release arbitrates normally from ptr 0.
    bus.req = 4'b0010;
    tick();
    chk("post_rst_ack", 32'(bus.ack), 32'(4'b0010));
    chk("post_rst_rand", 32'(bus.rand_data), 32'h01);
    bus.req = 4'b0000;
    tick();
    tick();
    chk("post_rst_idle", 32'(bus.busy), 32'd0);

`ifdef RAND_RESEED_EN
    seed_ld = 1'b1;
    seed    = 6'h00;
    tick();
    chk("reseed_zero", 32'(dut.lfsr_q), 32'h01);
    seed    = 6'h2A;
    tick();
    chk("reseed_2a", 32'(dut.lfsr_q), 32'h2A);
    seed_ld = 1'b0;
    bus.req = 4'b0001;
    tick();
    chk("reseed_ack", 32'(bus.ack), 32'(4'b0001));
    chk("reseed_rand", 32'(bus.rand_data), 32'h2A);
    bus.req = 4'b0000;
    tick();
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the random source.
REQ-002 Parameter DATA_W, default 6, random word width.
REQ-003 Parameter SEED, default 6'h01, LFSR reset value; must be nonzero.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 req  input  N_REQ  level request per requester, 4-phase: raise, hold until ack, then drop.
REQ-007 ack  output  N_REQ  one-hot, single-cycle grant pulse.
REQ-008 rand_data  output  DATA_W  random word, valid only in the cycle any ack bit is high.
REQ-009 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-010 Internal LFSR SHALL free-run: advance on every clk edge out of reset, independent of FSM state.
REQ-011 LFSR next value SHALL be {q[4:0], q[5]^q[4]}, period 63; a value of 0 SHALL be replaced by 6'h01 on the next edge.
REQ-012 FSM states SHALL be IDLE, GRANT and WAIT_REL.
REQ-013 IDLE: if any req bit is high at an edge, the FSM SHALL go to GRANT, select index g by round-robin starting at ptr, and set ack[g]=1 and rand_data = the pre-advance LFSR value.
REQ-014 GRANT SHALL last exactly one cycle, clear ack, and then go to WAIT_REL.
REQ-015 WAIT_REL SHALL return to IDLE on the first edge where req[g]==0; all other req bits are ignored in this state.
REQ-016 On each grant, ptr SHALL become (g+1) mod N_REQ.
REQ-017 Latency: req high before edge E in IDLE SHALL give ack high in the cycle after E.
REQ-018 Simultaneous requests SHALL be served in round-robin order with no requester starved; the maximum wait is N_REQ grants.
REQ-019 A requester holding req high through WAIT_REL SHALL NOT be re-granted until it drops req.
REQ-020 rand_data SHALL hold its last value outside grant cycles; consumers use it only while ack is high.

Reset
REQ-021 While rst=0: ack=0, rand_data=0, busy=0, FSM=IDLE, ptr=0, LFSR=SEED, all applied asynchronously.
REQ-022 Reset asserted mid-grant SHALL drop ack immediately with no glitch to another index.
REQ-023 After rst rises, the first edge SHALL evaluate req normally.

Configuration
REQ-024 Macro RAND_RESEED_EN: when defined, adds inputs seed_ld (1) and seed (DATA_W). With seed_ld=1 at an edge, LFSR loads seed; seed==0 loads 6'h01. seed_ld has priority over the free-run advance. FSM is unaffected.
REQ-025 Without RAND_RESEED_EN, these ports SHALL be absent and the LFSR only free-runs.

Structure
REQ-026 Shared package rand_pkg SHALL hold the FSM state encodings, the LFSR tap positions, the default SEED and DATA_W.
REQ-027 One sub-module, rr_pick, SHALL be combinational: it returns g and a found flag from req and ptr. The FSM, ptr and LFSR stay in rand_arbiter.

Verification
REQ-028 Check the free-run sequence: release rst with req=0; LFSR reads 6'h01, 02, 04, 08, 10, 21 on consecutive cycles.
REQ-029 Check single-requester timing: req=4'b0100 before the first edge after release; in the next cycle ack=4'b0100 and rand_data=6'h01. Hold req for 3 cycles, then drop it; expect no second ack and IDLE one edge after the drop.
REQ-030 Check round-robin order: req=4'b1111, each requester drops req the cycle after its ack; acks in order 0001, 0010, 0100, 1000; consecutive rand_data values are distinct.
REQ-031 Check pointer advance: after a grant to index 1, set req=4'b0011; next ack=4'b0001, and index 1 is not granted first.
REQ-032 Check mid-grant reset: pull rst low in a GRANT cycle; ack goes to 0 within the same cycle; after release, ptr=0 and LFSR=6'h01.
REQ-033 Check reseed (RAND_RESEED_EN only): seed_ld=1 with seed=6'h00 loads 6'h01; with seed=6'h2A, the next grant returns 6'h2A.
